// File: rtl/sorted_kv_pkg.sv
// sorted_kv_pkg: opcode and FSM state encodings shared by the sorted key/value table.
package sorted_kv_pkg;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_DEL = 2'b01, OP_UPD = 2'b10, OP_CLR = 2'b11} op_t;
   typedef enum logic [1:0] {IDLE, PROBE, SHIFT, FINISH} state_t;
endpackage

// File: rtl/sorted_kv_table_if.sv
// sorted_kv_table_if: lookup and table-operation ports of the sorted key/value table.
interface sorted_kv_table_if
   import sorted_kv_pkg::*;
#(
   parameter int KEY_W  = 16,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic              req;
   logic [KEY_W-1:0]  search;
   logic              rdy;
   logic              done;
   logic              found;
   logic [DATA_W-1:0] result;
   logic              op_req;
   op_t               op_code;
   logic [KEY_W-1:0]  op_key;
   logic [DATA_W-1:0] op_data;
   logic              op_done;
   logic              op_err;
   logic [CW-1:0]     num_entries;
   modport master (
      output req, search, op_req, op_code, op_key, op_data,
      input  rdy, done, found, result, op_done, op_err, num_entries
   );
   modport slave (
      input  req, search, op_req, op_code, op_key, op_data,
      output rdy, done, found, result, op_done, op_err, num_entries
   );
endinterface

// File: rtl/sorted_kv_probe.sv
// sorted_kv_probe: one lower-bound binary-search step over the key array.
module sorted_kv_probe #(
   parameter int KEY_W = 16,
   parameter int DEPTH = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic [CW-1:0]    i_lo,
   input  logic [CW-1:0]    i_hi,
   input  logic [KEY_W-1:0] i_target,
   input  logic [KEY_W-1:0] i_keys [DEPTH],
   output logic [CW-1:0]    o_lo,
   output logic [CW-1:0]    o_hi,
   output logic             o_settled
);
   localparam int AW = $clog2(DEPTH);
   logic [CW-1:0] w_sum;
   logic [CW-1:0] w_mid;
   logic          w_lt;
   // lo+hi never exceeds 2*DEPTH-1 while lo<hi, so CW bits cannot overflow
   assign w_sum     = i_lo + i_hi;
   assign w_mid     = w_sum >> 1;
   assign w_lt      = i_keys[w_mid[AW-1:0]] < i_target;
   assign o_lo      = w_lt ? w_mid + CW'(1) : i_lo;
   assign o_hi      = w_lt ? i_hi : w_mid;
   assign o_settled = i_lo == i_hi;
endmodule

// File: rtl/sorted_kv_table.sv
// sorted_kv_table: sorted key/value table with binary-search lookup and shifting insert/delete.
module sorted_kv_table
   import sorted_kv_pkg::*;
#(
   parameter int KEY_W  = 16,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32
) (
   input logic               clk,
   input logic               reset,
   sorted_kv_table_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [KEY_W-1:0]  r_keys [DEPTH];
   logic [DATA_W-1:0] r_vals [DEPTH];
   state_t            r_state;
   op_t               r_op;
   logic              r_lookup, r_hit, r_rdy, r_done, r_found, r_op_done, r_op_err;
   logic [KEY_W-1:0]  r_target;
   logic [DATA_W-1:0] r_op_data, r_result;
   logic [CW-1:0]     r_lo, r_hi, r_ptr, r_num;
   logic [CW-1:0]     w_lo, w_hi, w_ptr_up, w_ptr_dn;
   logic              w_settled, w_hit;

   sorted_kv_probe #(.KEY_W(KEY_W), .DEPTH(DEPTH), .CW(CW)) u_probe (
      .i_lo(r_lo), .i_hi(r_hi), .i_target(r_target), .i_keys(r_keys),
      .o_lo(w_lo), .o_hi(w_hi), .o_settled(w_settled)
   );

   // once settled, r_lo is the insertion / match index
   assign w_hit    = (r_lo < r_num) && (r_keys[r_lo[AW-1:0]] == r_target);
   assign w_ptr_up = r_ptr + CW'(1);
   assign w_ptr_dn = r_ptr - CW'(1);

   assign bus.rdy         = r_rdy;
   assign bus.done        = r_done;
   assign bus.found       = r_found;
   assign bus.result      = r_result;
   assign bus.op_done     = r_op_done;
   assign bus.op_err      = r_op_err;
   assign bus.num_entries = r_num;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= OP_ADD;
         r_lookup  <= 1'b0;
         r_hit     <= 1'b0;
         r_rdy     <= 1'b1;
         r_done    <= 1'b0;
         r_found   <= 1'b0;
         r_result  <= '0;
         r_op_done <= 1'b0;
         r_op_err  <= 1'b0;
         r_target  <= '0;
         r_op_data <= '0;
         r_lo      <= '0;
         r_hi      <= '0;
         r_ptr     <= '0;
         r_num     <= '0;
      end else begin
         r_done    <= 1'b0;
         r_op_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req) begin
                  r_target <= bus.search;
                  r_lookup <= 1'b1;
                  r_lo     <= '0;
                  r_hi     <= r_num;
                  r_rdy    <= 1'b0;
                  r_state  <= PROBE;
               end else if (bus.op_req) begin
                  r_target  <= bus.op_key;
                  r_op_data <= bus.op_data;
                  r_op      <= bus.op_code;
                  r_lookup  <= 1'b0;
                  r_lo      <= '0;
                  r_hi      <= r_num;
                  r_rdy     <= 1'b0;
                  if (bus.op_code == OP_CLR) begin
                     r_num     <= '0;
                     r_op_err  <= 1'b0;
                     r_op_done <= 1'b1;
                     r_state   <= FINISH;
                  end else begin
                     r_state <= PROBE;
                  end
               end
            end
            PROBE: begin
               if (!w_settled) begin
                  r_lo <= w_lo;
                  r_hi <= w_hi;
               end else begin
                  r_hit <= w_hit;
                  if (r_lookup) begin
                     r_done   <= 1'b1;
                     r_found  <= w_hit;
                     r_result <= w_hit ? r_vals[r_lo[AW-1:0]] : '0;
                     r_state  <= FINISH;
                  end else if (r_op == OP_ADD && !w_hit && r_num != FULL) begin
                     r_ptr   <= r_num;
                     r_state <= SHIFT;
                  end else if (r_op == OP_DEL && w_hit) begin
                     r_ptr   <= r_lo;
                     r_state <= SHIFT;
                  end else begin
                     r_op_err  <= !(r_op == OP_UPD && w_hit);
                     r_op_done <= 1'b1;
                     r_state   <= FINISH;
                  end
               end
            end
            SHIFT: begin
               if (r_op == OP_ADD) begin
                  if (r_ptr > r_lo) begin
                     r_ptr <= w_ptr_dn;
                  end else begin
                     r_num     <= r_num + CW'(1);
                     r_op_err  <= 1'b0;
                     r_op_done <= 1'b1;
                     r_state   <= FINISH;
                  end
               end else if (w_ptr_up < r_num) begin
                  r_ptr <= w_ptr_up;
               end else begin
                  r_num     <= r_num - CW'(1);
                  r_op_err  <= 1'b0;
                  r_op_done <= 1'b1;
                  r_state   <= FINISH;
               end
            end
            FINISH: begin
               r_rdy   <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   // storage is deliberately not reset; numEntries=0 masks stale contents
   always_ff @(posedge clk) begin
      if (r_state == SHIFT && r_op == OP_ADD) begin
         if (r_ptr > r_lo) begin
            r_keys[r_ptr[AW-1:0]] <= r_keys[w_ptr_dn[AW-1:0]];
            r_vals[r_ptr[AW-1:0]] <= r_vals[w_ptr_dn[AW-1:0]];
         end else begin
            r_keys[r_lo[AW-1:0]] <= r_target;
            r_vals[r_lo[AW-1:0]] <= r_op_data;
         end
      end else if (r_state == SHIFT && w_ptr_up < r_num) begin
         r_keys[r_ptr[AW-1:0]] <= r_keys[w_ptr_up[AW-1:0]];
         r_vals[r_ptr[AW-1:0]] <= r_vals[w_ptr_up[AW-1:0]];
      end else if (r_state == FINISH && !r_lookup && r_op == OP_UPD && r_hit) begin
         r_vals[r_lo[AW-1:0]] <= r_op_data;
      end
   end
endmodule

// File: tb/tb_sorted_kv_table.sv
// tb_sorted_kv_table: directed checks of lookup, add/delete/update/clear and reset behaviour.
module tb_sorted_kv_table;
   import sorted_kv_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;

   sorted_kv_table_if bus ();
   sorted_kv_table dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic wait_rdy();
      int g = 0;
      @(negedge clk);
      while (!bus.rdy && g < 50) begin
         @(negedge clk);
         g++;
      end
      chk("rdy_wait", 32'(bus.rdy), 1);
   endtask

   task automatic lookup(input logic [15:0] k, output logic f, output logic [15:0] r, output int lat);
      wait_rdy();
      bus.req = 1'b1;
      bus.search = k;
      @(posedge clk); #1;
      bus.req = 1'b0;
      lat = 0;
      while (!bus.done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      f = bus.found;
      r = bus.result;
   endtask

   task automatic lk(input string tag, input logic [15:0] k, input logic ef, input logic [15:0] er);
      logic f;
      logic [15:0] r;
      int lat;
      lookup(k, f, r, lat);
      chk({tag, ".found"}, 32'(f), 32'(ef));
      if (ef) chk({tag, ".result"}, 32'(r), 32'(er));
      chk({tag, ".lat"}, 32'(lat <= 8), 1);
   endtask

   task automatic op(input string tag, input op_t c, input logic [15:0] k, input logic [15:0] d,
                     input logic ee, input int en);
      int lat;
      wait_rdy();
      bus.op_req = 1'b1;
      bus.op_code = c;
      bus.op_key = k;
      bus.op_data = d;
      @(posedge clk); #1;
      bus.op_req = 1'b0;
      lat = 0;
      while (!bus.op_done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".err"}, 32'(bus.op_err), 32'(ee));
      chk({tag, ".num"}, 32'(bus.num_entries), 32'(en));
      chk({tag, ".lat"}, 32'(lat <= 40), 1);
   endtask

   initial begin
      logic f, sd, fd;
      logic [15:0] r, rd;
      int lat, cyc, pulses;
      bus.req = 1'b0;
      bus.search = '0;
      bus.op_req = 1'b0;
      bus.op_code = OP_ADD;
      bus.op_key = '0;
      bus.op_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.num", 32'(bus.num_entries), 0);
      chk("rst.rdy", 32'(bus.rdy), 1);
      chk("rst.done", 32'(bus.done), 0);
      chk("rst.op_done", 32'(bus.op_done), 0);
      chk("rst.result", 32'(bus.result), 0);
      @(negedge clk);
      reset = 1'b0;

      op("add29", OP_ADD, 16'h29, 16'hA, 1'b0, 1);
      op("add23", OP_ADD, 16'h23, 16'hB, 1'b0, 2);
      op("add26", OP_ADD, 16'h26, 16'hC, 1'b0, 3);
      lk("lk23", 16'h23, 1'b1, 16'hB);
      lk("lk26", 16'h26, 1'b1, 16'hC);
      lk("lk29", 16'h29, 1'b1, 16'hA);
      lk("lk24", 16'h24, 1'b0, 16'h0);
      lk("lk30", 16'h30, 1'b0, 16'h0);
      lk("lk01", 16'h01, 1'b0, 16'h0);

      op("del23", OP_DEL, 16'h23, 16'h0, 1'b0, 2);
      lk("lk29b", 16'h29, 1'b1, 16'hA);
      lk("lk23b", 16'h23, 1'b0, 16'h0);
      op("del23again", OP_DEL, 16'h23, 16'h0, 1'b1, 2);
      op("upd29", OP_UPD, 16'h29, 16'h5, 1'b0, 2);
      lk("lk29c", 16'h29, 1'b1, 16'h5);
      lk("lk26b", 16'h26, 1'b1, 16'hC);
      op("upd_miss", OP_UPD, 16'h77, 16'h1, 1'b1, 2);

      // simultaneous lookup and add: the lookup is served first
      wait_rdy();
      bus.req = 1'b1;
      bus.search = 16'h26;
      bus.op_req = 1'b1;
      bus.op_code = OP_ADD;
      bus.op_key = 16'h40;
      bus.op_data = 16'h7;
      @(posedge clk); #1;
      bus.req = 1'b0;
      sd = 1'b0; fd = 1'b0; rd = '0; cyc = 0;
      while (!bus.op_done && cyc < 200) begin
         if (sd && !bus.rdy) bus.op_req = 1'b0;
         if (bus.done) begin
            sd = 1'b1;
            fd = bus.found;
            rd = bus.result;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.op_req = 1'b0;
      chk("both.lookup_first", 32'(sd), 1);
      chk("both.found", 32'(fd), 1);
      chk("both.result", 32'(rd), 16'hC);
      chk("both.op_done", 32'(bus.op_done), 1);
      chk("both.err", 32'(bus.op_err), 0);
      chk("both.num", 32'(bus.num_entries), 3);
      lk("lk40", 16'h40, 1'b1, 16'h7);

      op("clr", OP_CLR, 16'h0, 16'h0, 1'b0, 0);
      lookup(16'h29, f, r, lat);
      chk("empty.found", 32'(f), 0);
      chk("empty.lat", 32'(lat <= 2), 1);

      // descending keys so every add inserts at slot 0 and shifts the whole table
      for (int i = 0; i < 32; i++) op("fill", OP_ADD, 16'(16'h200 - 4 * i), 16'(i), 1'b0, i + 1);
      lk("lkmax", 16'h200, 1'b1, 16'd0);
      lk("lkmin", 16'h184, 1'b1, 16'd31);
      lk("lkmid", 16'h1EC, 1'b1, 16'd5);
      lk("lkgap", 16'h1FE, 1'b0, 16'h0);
      op("full_new", OP_ADD, 16'h300, 16'h1, 1'b1, 32);
      op("full_dup", OP_ADD, 16'h200, 16'h1, 1'b1, 32);
      lk("lkmax2", 16'h200, 1'b1, 16'd0);

      op("clr2", OP_CLR, 16'h0, 16'h0, 1'b0, 0);
      for (int i = 0; i < 8; i++) op("fill8", OP_ADD, 16'(16'h10 * (i + 1)), 16'(i), 1'b0, i + 1);
      wait_rdy();
      bus.op_req = 1'b1;
      bus.op_code = OP_ADD;
      bus.op_key = 16'h01;
      bus.op_data = 16'h9;
      @(posedge clk); #1;
      bus.op_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("mid.busy", 32'(bus.rdy), 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid.num", 32'(bus.num_entries), 0);
      chk("mid.rdy", 32'(bus.rdy), 1);
      chk("mid.op_done", 32'(bus.op_done), 0);
      chk("mid.done", 32'(bus.done), 0);
      chk("mid.err", 32'(bus.op_err), 0);
      @(posedge clk); #1;
      chk("mid.num2", 32'(bus.num_entries), 0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(posedge clk); #1;
         pulses += int'(bus.op_done | bus.done);
      end
      chk("mid.no_pulse", 32'(pulses), 0);
      lk("post_rst", 16'h10, 1'b0, 16'h0);
      op("post_add", OP_ADD, 16'h05, 16'h3, 1'b0, 1);
      lk("post_lk", 16'h05, 1'b1, 16'h3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/sorted_kv_table.md
SORTED_KV_TABLE -- requirements
Module: sorted_kv_table

Interface
REQ-001 Parameter: KEY_W, 16, key width in bits.
REQ-002 Parameter: DATA_W, 16, data width in bits.
REQ-003 Parameter: DEPTH, 32, entry count; SHALL be a power of two, at least 4.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  1  lookup request, sampled in IDLE; search  in  KEY_W  lookup key, captured with req.
REQ-007 rdy  out  1  high only in IDLE; both requests are accepted only while rdy=1.
REQ-008 done  out  1  one-cycle lookup-complete pulse; found  out  1  key hit, valid with done; result  out  DATA_W  hit data, held until next done.
REQ-009 opReq  in  1  table-operation request; opCode  in  2  00 add, 01 delete, 10 update, 11 clear; opKey  in  KEY_W; opData  in  DATA_W, all captured with opReq.
REQ-010 opDone  out  1  one-cycle operation-complete pulse; opErr  out  1  failure flag, valid with opDone.
REQ-011 numEntries  out  $clog2(DEPTH)+1  current valid entry count, 0..DEPTH.

Function
REQ-012 Entries 0..numEntries-1 SHALL hold strictly ascending unique keys, each with one data word; higher slots are don't-care.
REQ-013 FSM states: IDLE, PROBE, SHIFT, FINISH; reset state IDLE.
REQ-014 IDLE: req=1 -> capture search, lo=0, hi=numEntries, go to PROBE; otherwise opReq=1 -> capture op fields; clear goes directly to FINISH, all other ops go to PROBE. req wins over a simultaneous opReq; opReq SHALL be held by the requester until accepted.
REQ-015 PROBE: lower-bound binary search, one probe per cycle: mid=(lo+hi)>>1, computed at $clog2(DEPTH)+1 bits; key(mid)<target -> lo=mid+1, else hi=mid; when lo==hi, idx=lo, hit=(idx<numEntries && key(idx)==target), go to FINISH or SHIFT.
REQ-016 Lookup latency: accept to done SHALL be at most $clog2(DEPTH)+3 cycles; an empty table gives done with found=0 within 3 cycles.
REQ-017 Add, key absent, numEntries<DEPTH -> SHIFT moves one entry per cycle from numEntries-1 down to idx into the next slot up, writes opKey/opData at idx, increments numEntries.
REQ-018 Add when the key is already present or numEntries==DEPTH -> opErr=1, table unchanged.
REQ-019 Delete, hit -> SHIFT moves entries idx+1..numEntries-1 down by one, one per cycle, then decrements numEntries; miss -> opErr=1.
REQ-020 Update, hit -> data(idx)=opData in FINISH; miss -> opErr=1.
REQ-021 Clear -> numEntries=0 in one cycle, opErr=0, no per-entry writes.
REQ-022 FINISH: pulse done (lookup) or opDone (operation) for exactly one cycle, then return to IDLE; found, result and opErr SHALL keep their values until the next respective pulse.
REQ-023 Input changes outside IDLE SHALL be ignored; no request SHALL abort an operation in progress.
REQ-024 Worst-case operation latency SHALL be at most $clog2(DEPTH)+DEPTH+3 cycles.

Reset
REQ-025 Asserting reset at any cycle, including mid-SHIFT, SHALL give: state IDLE, numEntries=0, done/found/opDone/opErr=0, result=0, rdy=1.
REQ-026 Storage contents SHALL NOT be reset; they are masked by numEntries=0.

Structure
REQ-027 The opcode encoding (op_t) and the FSM state encoding (state_t) SHALL be defined in a shared package, sorted_kv_pkg.
REQ-028 Key/data storage SHALL be a register array held inside the module; the one sub-module is sorted_kv_probe, the combinational mid/compare/lo-hi update step.

Verification
REQ-029 Reset, add 0x29/0xA, add 0x23/0xB, add 0x26/0xC -> numEntries=3, keys in order 23,26,29, no opErr.
REQ-030 Lookup 0x26 -> found=1, result=0xC; lookup 0x24 and lookup 0x30 -> found=0; each done within $clog2(DEPTH)+3 cycles.
REQ-031 Fill to DEPTH=32 entries, then add a new key -> opErr=1, numEntries=32; add a duplicate key -> opErr=1.
REQ-032 Delete 0x23 -> numEntries=2, lookup 0x29 -> result 0xA; delete 0x23 again -> opErr=1; update 0x29 to 0x5 -> lookup returns 0x5.
REQ-033 req and opReq both asserted in IDLE -> the lookup completes first, then the op; clear -> numEntries=0, lookup 0x29 -> found=0.
REQ-034 Assert reset mid-SHIFT of an add into an 8-entry table -> next cycle numEntries=0, rdy=1, no done/opDone pulse.
